mem_mport_resp: RTL and testbench
=================================

Name: mem_mport_resp

Overview:
- Parametrised multi-port memory responder for core-level benches and small SoC builds; generalises the single-port zero-latency imem/dmem models.
- NUM_PORT requesters (e.g. port 0 = imem, port 1 = dmem) share one row-organised storage array through a round-robin arbiter.
- Reads have configurable latency; writes use byte enables.
- Every request completes with a one-cycle ack pulse. The level request is held until acked.

Parameters:
- NUM_PORT, 2, number of requester ports (1..8)
- REG_WIDTH, 32, data width in bits (multiple of 8)
- MEM_ADDR_WIDTH, 12, byte-address width
- RD_LATENCY, 1, cycles from grant to rd_ack (1..4)
- Derived: BYTES_PER_ROW = REG_WIDTH/8; ROW_AW = MEM_ADDR_WIDTH - $clog2(BYTES_PER_ROW); depth 2**ROW_AW rows

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_addr  in  NUM_PORT*MEM_ADDR_WIDTH  byte address per port (port p at slice p)
- req_rd_en  in  NUM_PORT  read request, level, held until rd_ack
- req_wr_en  in  NUM_PORT  write request, level, held until wr_ack
- req_wr_data  in  NUM_PORT*REG_WIDTH  write data per port
- req_wr_ben  in  NUM_PORT*BYTES_PER_ROW  byte enables per port
- rsp_rd_ack  out  NUM_PORT  one-cycle read completion pulse
- rsp_rd_data  out  NUM_PORT*REG_WIDTH  read data, valid while rsp_rd_ack high
- rsp_wr_ack  out  NUM_PORT  one-cycle write completion pulse
- rsp_err  out  NUM_PORT  present only with MEM_ALIGN_CHECK_EN

Behaviour:
- Reset (rst low, async): all rsp_* outputs 0, read pipeline valids cleared, round-robin pointer = port 0, busy mask cleared. The storage array named mem is not reset. Benches preload it hierarchically (mem[row]).
- Port eligibility: req_rd_en or req_wr_en high, and busy[p] = 0.
- Arbitration: at most one grant per cycle. Round-robin search starts at the pointer. After a grant to p, the pointer moves to p+1 mod NUM_PORT. With no eligible port, the pointer holds.
- Row index: req_addr >> $clog2(BYTES_PER_ROW). Low address bits are ignored (unless the optional feature is enabled).
- Both enables high on a granted port: the write is served, the read is ignored this grant. The read is served on a later grant if still held.
- Write granted in cycle t:
  - Enabled bytes are committed at the clock edge ending cycle t.
  - rsp_wr_ack[p] = 1 in cycle t+1 only.
- Read granted in cycle t:
  - Row data is captured at the edge ending cycle t (post any earlier-cycle writes) and travels an RD_LATENCY-deep pipeline tagged with the port id.
  - rsp_rd_ack[p] and rsp_rd_data[p] are valid in cycle t+RD_LATENCY only.
  - rsp_rd_data for a port holds its last value otherwise.
- Busy mask:
  - busy[p] is set at grant and cleared at the end of the ack cycle.
  - The port cannot be re-granted while its en is still high during the ack cycle.
  - A new request from the same port is eligible the cycle after its ack.
- Throughput: one op per cycle aggregate. Per port, one op every RD_LATENCY+1 cycles (reads) or 2 cycles (writes).
- Read-after-write, different ports: the write at t is visible to any read granted at t+1 or later.
- Reset mid-operation: in-flight reads are dropped with no ack. Writes already committed stay in mem.
- Requester dropping en before ack: protocol violation. The granted op still completes and acks.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - rsp_err port exists.
  - A granted request with a nonzero req_addr[$clog2(BYTES_PER_ROW)-1:0] is misaligned.
  - A misaligned write suppresses the commit; wr_ack is still pulsed, with rsp_err[p] = 1 in the same cycle.
  - A misaligned read returns rsp_rd_data = 0 with rsp_err[p] = 1 coincident with rd_ack.
- Undefined: no rsp_err port; low address bits are silently ignored.

Test Plan:
- Preload mem[0] = 32'h01234567. Port 1 reads addr 12'h000 with RD_LATENCY=1 -> rsp_rd_ack[1] one cycle after grant, data 32'h01234567, ack single-cycle.
- Port 1 writes addr 12'h004, data 32'hAABBCCDD, ben 4'b0101, over mem[1] = 0 -> wr_ack next cycle; mem[1] = 32'h00BB00DD. A subsequent read returns that value.
- Ports 0 and 1 both request reads every cycle, NUM_PORT=2 -> grants alternate 0,1,0,1. No port is granted twice within its busy window. Acks never coincide for the same port.
- RD_LATENCY=3: read grant at cycle 10 -> ack at cycle 13. rst asserted at cycle 11 -> no ack, all outputs 0, pointer at 0.
- Port 0 writes 32'h12345678 to addr 12'h010 at cycle t; port 1 reads 12'h010, granted t+1 -> returns 32'h12345678.
- With MEM_ALIGN_CHECK_EN: write to 12'h002 -> wr_ack and rsp_err together, mem unchanged. Read 12'h001 -> data 0, rsp_err = 1.

Source files
------------

// File: rtl/mem_mport_resp_if.sv
// Request/response bundle between NUM_PORT requesters and mem_mport_resp.
// rsp_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_mport_resp_if #(
  parameter int NUM_PORT       = 2,
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 12
);
  localparam int BYTES_PER_ROW = REG_WIDTH / 8;

  // Handshake: a requester raises req_rd_en/req_wr_en and holds it, with stable
  // address/data/ben, until the matching one-cycle rsp_*_ack pulse; it must drop
  // the enable at the end of the ack cycle or the next op is taken as a new request.
  logic [NUM_PORT*MEM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORT-1:0]                req_rd_en;
  logic [NUM_PORT-1:0]                req_wr_en;
  logic [NUM_PORT*REG_WIDTH-1:0]      req_wr_data;
  logic [NUM_PORT*BYTES_PER_ROW-1:0]  req_wr_ben;
  logic [NUM_PORT-1:0]                rsp_rd_ack;
  logic [NUM_PORT*REG_WIDTH-1:0]      rsp_rd_data;
  logic [NUM_PORT-1:0]                rsp_wr_ack;
`ifdef MEM_ALIGN_CHECK_EN
  logic [NUM_PORT-1:0]                rsp_err;

  modport master (
    output req_addr, req_rd_en, req_wr_en, req_wr_data, req_wr_ben,
    input  rsp_rd_ack, rsp_rd_data, rsp_wr_ack, rsp_err
  );
  modport slave (
    input  req_addr, req_rd_en, req_wr_en, req_wr_data, req_wr_ben,
    output rsp_rd_ack, rsp_rd_data, rsp_wr_ack, rsp_err
  );
`else
  modport master (
    output req_addr, req_rd_en, req_wr_en, req_wr_data, req_wr_ben,
    input  rsp_rd_ack, rsp_rd_data, rsp_wr_ack
  );
  modport slave (
    input  req_addr, req_rd_en, req_wr_en, req_wr_data, req_wr_ben,
    output rsp_rd_ack, rsp_rd_data, rsp_wr_ack
  );
`endif
endinterface

// File: rtl/mem_mport_resp.sv
// Multi-port memory responder: round-robin arbitration onto one row array,
// byte-enabled writes, RD_LATENCY-deep read pipeline. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_mport_resp #(
  parameter int NUM_PORT       = 2,
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int RD_LATENCY     = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_mport_resp_if.slave  bus
);
  localparam int BYTES_PER_ROW = REG_WIDTH / 8;
  localparam int BOFF   = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 0;
  localparam int ROW_AW = MEM_ADDR_WIDTH - BOFF;
  localparam int DEPTH  = 1 << ROW_AW;
  localparam int PW     = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [REG_WIDTH-1:0] mem [DEPTH];

  logic [NUM_PORT-1:0]       r_busy;
  logic [NUM_PORT-1:0]       r_wr_ack;
  logic [PW-1:0]             r_ptr;
  logic [REG_WIDTH-1:0]      r_hold [NUM_PORT];
  logic [RD_LATENCY-1:0]     r_pv;
  logic [PW-1:0]             r_pport [RD_LATENCY];
  logic [REG_WIDTH-1:0]      r_pdata [RD_LATENCY];

  logic [NUM_PORT-1:0]       w_elig;
  logic [NUM_PORT-1:0]       w_gnt_oh;
  logic [NUM_PORT-1:0]       w_rd_ack;
  logic                      w_gnt_vld;
  logic [PW-1:0]             w_gnt_idx;
  logic                      w_gnt_wr;
  logic                      w_gnt_rd;
  logic                      w_mis;
  logic                      w_do_wr;
  logic [MEM_ADDR_WIDTH-1:0] w_gnt_addr;
  logic [REG_WIDTH-1:0]      w_gnt_wdata;
  logic [BYTES_PER_ROW-1:0]  w_gnt_ben;
  logic [ROW_AW-1:0]         w_row;
  int                        w_best;
  int                        w_off;

  assign w_elig = (bus.req_rd_en | bus.req_wr_en) & ~r_busy;

  // Pick the eligible port with the smallest distance from the pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_best    = NUM_PORT;
    w_off     = 0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (w_elig[p]) begin
        w_off = (p >= int'(r_ptr)) ? (p - int'(r_ptr)) : (p + NUM_PORT - int'(r_ptr));
        if (w_off < w_best) begin
          w_best    = w_off;
          w_gnt_vld = 1'b1;
          w_gnt_idx = PW'(p);
        end
      end
    end
  end

  assign w_gnt_addr  = bus.req_addr[w_gnt_idx*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
  assign w_gnt_wdata = bus.req_wr_data[w_gnt_idx*REG_WIDTH +: REG_WIDTH];
  assign w_gnt_ben   = bus.req_wr_ben[w_gnt_idx*BYTES_PER_ROW +: BYTES_PER_ROW];
  assign w_row       = ROW_AW'(w_gnt_addr >> BOFF);
  // Write wins when both enables are high; the read waits for a later grant.
  assign w_gnt_wr    = w_gnt_vld & bus.req_wr_en[w_gnt_idx];
  assign w_gnt_rd    = w_gnt_vld & ~w_gnt_wr;
  assign w_gnt_oh    = w_gnt_vld ? (NUM_PORT'(1) << w_gnt_idx) : '0;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [MEM_ADDR_WIDTH-1:0] LOW_MASK = MEM_ADDR_WIDTH'((1 << BOFF) - 1);
  logic [NUM_PORT-1:0]   r_wr_err;
  logic [RD_LATENCY-1:0] r_perr;
  assign w_mis = |(w_gnt_addr & LOW_MASK);
`else
  assign w_mis = 1'b0;
`endif

  assign w_do_wr = w_gnt_wr & ~w_mis;

  // Storage is deliberately not reset; benches preload it hierarchically.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      for (int b = 0; b < BYTES_PER_ROW; b++) begin
        if (w_gnt_ben[b]) mem[w_row][b*8 +: 8] <= w_gnt_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_rd_ack = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      w_rd_ack[p] = r_pv[RD_LATENCY-1] && (r_pport[RD_LATENCY-1] == PW'(p));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= '0;
      r_wr_ack <= '0;
      r_ptr    <= '0;
      r_pv     <= '0;
      for (int p = 0; p < NUM_PORT; p++) r_hold[p] <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pport[s] <= '0;
        r_pdata[s] <= '0;
      end
`ifdef MEM_ALIGN_CHECK_EN
      r_wr_err <= '0;
      r_perr   <= '0;
`endif
    end else begin
      r_busy   <= (r_busy | w_gnt_oh) & ~(r_wr_ack | w_rd_ack);
      r_wr_ack <= w_gnt_wr ? w_gnt_oh : '0;
      if (w_gnt_vld) r_ptr <= (w_gnt_idx == PW'(NUM_PORT - 1)) ? '0 : w_gnt_idx + 1'b1;
      // Row is sampled before this edge's write lands, i.e. after all earlier writes.
      r_pv[0]    <= w_gnt_rd;
      r_pport[0] <= w_gnt_idx;
      r_pdata[0] <= w_mis ? '0 : mem[w_row];
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pv[s]    <= r_pv[s-1];
        r_pport[s] <= r_pport[s-1];
        r_pdata[s] <= r_pdata[s-1];
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        if (w_rd_ack[p]) r_hold[p] <= r_pdata[RD_LATENCY-1];
      end
`ifdef MEM_ALIGN_CHECK_EN
      r_wr_err  <= (w_gnt_wr && w_mis) ? w_gnt_oh : '0;
      r_perr[0] <= w_mis;
      for (int s = 1; s < RD_LATENCY; s++) r_perr[s] <= r_perr[s-1];
`endif
    end
  end

  assign bus.rsp_rd_ack = w_rd_ack;
  assign bus.rsp_wr_ack = r_wr_ack;

  always_comb begin
    bus.rsp_rd_data = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      bus.rsp_rd_data[p*REG_WIDTH +: REG_WIDTH] = w_rd_ack[p] ? r_pdata[RD_LATENCY-1] : r_hold[p];
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    bus.rsp_err = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      bus.rsp_err[p] = r_wr_err[p] | (w_rd_ack[p] & r_perr[RD_LATENCY-1]);
    end
  end
`endif
endmodule

// File: tb/tb_mem_mport_resp.sv
// Bench for mem_mport_resp: scoreboard with per-port expected queues plus a
// second RD_LATENCY=3 instance for latency and mid-operation reset.
module tb_mem_mport_resp;
  localparam int NP = 2;
  localparam int W  = 32;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst3 = 1'b0;
  always #5 clk = ~clk;

  mem_mport_resp_if #(.NUM_PORT(NP), .REG_WIDTH(W), .MEM_ADDR_WIDTH(AW)) bus ();
  mem_mport_resp_if #(.NUM_PORT(NP), .REG_WIDTH(W), .MEM_ADDR_WIDTH(AW)) bus3 ();

  mem_mport_resp #(.NUM_PORT(NP), .REG_WIDTH(W), .MEM_ADDR_WIDTH(AW), .RD_LATENCY(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  mem_mport_resp #(.NUM_PORT(NP), .REG_WIDTH(W), .MEM_ADDR_WIDTH(AW), .RD_LATENCY(3))
    dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q0[$];   // {err, is_wr, data}
  logic [W+1:0] exp_q1[$];
  int ack_log[$];
  int lat, lat0, lat1, f0, f1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int p = 0; p < NP; p++) begin
          if (bus.rsp_rd_ack[p] || bus.rsp_wr_ack[p]) begin
            ack_log.push_back(p);
            check("ack_excl", W'(bus.rsp_rd_ack[p] & bus.rsp_wr_ack[p]), '0);
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: port %0d acked with nothing expected", p);
            end else begin
              if (p == 0) e = exp_q0.pop_front();
              else        e = exp_q1.pop_front();
              check("ack_kind", W'(bus.rsp_wr_ack[p]), W'(e[W]));
              if (!e[W]) check("rd_data", bus.rsp_rd_data[p*W +: W], e[W-1:0]);
`ifdef MEM_ALIGN_CHECK_EN
              check("rsp_err", W'(bus.rsp_err[p]), W'(e[W+1]));
`endif
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Call at posedge+#1; returns at posedge+#1 after the ack cycle.
  task automatic do_req(input int p, input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [3:0] be,
                        input logic [W-1:0] exp, input bit err, output int l);
    if (p == 0) exp_q0.push_back({err, wr, exp});
    else        exp_q1.push_back({err, wr, exp});
    bus.req_addr[p*AW +: AW]   = a;
    bus.req_wr_data[p*W +: W]  = d;
    bus.req_wr_ben[p*4 +: 4]   = be;
    bus.req_rd_en[p]           = rd;
    bus.req_wr_en[p]           = wr;
    l = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_rd_ack[p] || bus.rsp_wr_ack[p]) begin
        l = n;
        break;
      end
    end
    if (l < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: port %0d got no ack within 20 cycles", p);
    end
    @(posedge clk);
    #1;
    bus.req_rd_en[p] = 1'b0;
    bus.req_wr_en[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.req_addr = '0;  bus.req_rd_en = '0;  bus.req_wr_en = '0;
    bus.req_wr_data = '0; bus.req_wr_ben = '0;
    bus3.req_addr = '0; bus3.req_rd_en = '0; bus3.req_wr_en = '0;
    bus3.req_wr_data = '0; bus3.req_wr_ben = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_ack",  W'(bus.rsp_rd_ack), '0);
    check("rst_wr_ack",  W'(bus.rsp_wr_ack), '0);
    check("rst_rd_data", bus.rsp_rd_data[W-1:0] | bus.rsp_rd_data[2*W-1:W], '0);

    dut.mem[0] = 32'h01234567;
    dut.mem[1] = 32'h00000000;
    dut.mem[2] = 32'hA5A50002;
    dut.mem[3] = 32'h5A5A0003;
    dut.mem[4] = 32'hDEADBEEF;
    dut.mem[5] = 32'h00000000;
    dut.mem[1023] = 32'h0F0F0F0F;
    dut3.mem[0] = 32'h33333333;
    dut3.mem[1] = 32'h44444444;
    @(posedge clk); #1;
    rst = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    // Single read, latency 1, single-cycle ack, data hold afterwards
    do_req(1, 1'b0, 1'b1, 12'h000, '0, 4'h0, 32'h01234567, 1'b0, lat);
    check("rd_latency", W'(lat), 32'd1);
    @(negedge clk);
    check("rd_ack_single", W'(bus.rsp_rd_ack), '0);
    check("rd_data_hold", bus.rsp_rd_data[W +: W], 32'h01234567);
    @(posedge clk); #1;

    // Byte-enabled write then read back
    do_req(1, 1'b1, 1'b0, 12'h004, 32'hAABBCCDD, 4'b0101, '0, 1'b0, lat);
    check("wr_latency", W'(lat), 32'd1);
    check("wr_mem1", dut.mem[1], 32'h00BB00DD);
    do_req(1, 1'b0, 1'b1, 12'h004, '0, 4'h0, 32'h00BB00DD, 1'b0, lat);

    // Both ports reading back-to-back: acks must alternate 0,1,0,1,...
    ack_log.delete();
    fork
      begin
        do_req(0, 1'b0, 1'b1, 12'h008, '0, 4'h0, 32'hA5A50002, 1'b0, lat0);
        do_req(0, 1'b0, 1'b1, 12'h00C, '0, 4'h0, 32'h5A5A0003, 1'b0, lat0);
        do_req(0, 1'b0, 1'b1, 12'h00B, '0, 4'h0, 32'hA5A50002, 1'b0, lat0);
      end
      begin
        do_req(1, 1'b0, 1'b1, 12'h00C, '0, 4'h0, 32'h5A5A0003, 1'b0, lat1);
        do_req(1, 1'b0, 1'b1, 12'h008, '0, 4'h0, 32'hA5A50002, 1'b0, lat1);
        do_req(1, 1'b0, 1'b1, 12'h00C, '0, 4'h0, 32'h5A5A0003, 1'b0, lat1);
      end
    join
    check("rr_count", W'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) check("rr_order", W'(ack_log[i]), W'(i % 2));

    // Write on port 0, read of the same row on port 1 granted the next cycle
    fork
      do_req(0, 1'b1, 1'b0, 12'h010, 32'h12345678, 4'hF, '0, 1'b0, lat0);
      do_req(1, 1'b0, 1'b1, 12'h010, '0, 4'h0, 32'h12345678, 1'b0, lat1);
    join
    check("raw_rd_lat", W'(lat1), 32'd2);

    // Both enables high: only the write is served
    do_req(0, 1'b1, 1'b1, 12'h014, 32'hCAFEF00D, 4'hF, '0, 1'b0, lat);
    check("both_en_mem5", dut.mem[5], 32'hCAFEF00D);

    // Top row of the array
    do_req(0, 1'b1, 1'b0, 12'hFFC, 32'h11223344, 4'b1100, '0, 1'b0, lat);
    do_req(1, 1'b0, 1'b1, 12'hFFF, '0, 4'h0, 32'h11220F0F, 1'b0, lat);

`ifdef MEM_ALIGN_CHECK_EN
    do_req(0, 1'b1, 1'b0, 12'h002, 32'hFFFFFFFF, 4'hF, '0, 1'b1, lat);
    check("mis_wr_mem0", dut.mem[0], 32'h01234567);
    do_req(1, 1'b0, 1'b1, 12'h001, '0, 4'h0, 32'h00000000, 1'b1, lat);
`endif

    // RD_LATENCY=3 instance: latency, reset mid-read, pointer back to port 0
    bus3.req_addr = '0;
    bus3.req_rd_en = 2'b01;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus3.rsp_rd_ack[0]) begin
        lat = n;
        check("l3_data", bus3.rsp_rd_data[W-1:0], 32'h33333333);
        break;
      end
    end
    check("l3_latency", W'(lat), 32'd3);
    @(posedge clk); #1;
    bus3.req_rd_en = 2'b00;
    @(posedge clk); #1;
    bus3.req_rd_en = 2'b01;
    @(posedge clk); #1;
    rst3 = 1'b0;
    bus3.req_rd_en = 2'b00;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("l3_rst_rd_ack", W'(bus3.rsp_rd_ack) | W'(bus3.rsp_wr_ack), '0);
      check("l3_rst_data", bus3.rsp_rd_data[W-1:0] | bus3.rsp_rd_data[2*W-1:W], '0);
    end
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    bus3.req_addr = {12'h004, 12'h000};
    bus3.req_rd_en = 2'b11;
    f0 = -1;
    f1 = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus3.rsp_rd_ack[0] && f0 < 0) begin
        f0 = n;
        check("l3_p0_data", bus3.rsp_rd_data[W-1:0], 32'h33333333);
      end
      if (bus3.rsp_rd_ack[1] && f1 < 0) begin
        f1 = n;
        check("l3_p1_data", bus3.rsp_rd_data[W +: W], 32'h44444444);
      end
      if (f0 >= 0 && f1 >= 0) break;
    end
    check("l3_ptr_p0_first", W'(f0), 32'd3);
    check("l3_ptr_p1_second", W'(f1), 32'd4);
    @(posedge clk); #1;
    bus3.req_rd_en = 2'b00;

    repeat (6) @(posedge clk);
    check("queues_empty", W'(exp_q0.size() + exp_q1.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
